// File: rtl/iir_fast_top.sv
// ----------------------------------------------------------------------------
// iir_fast_top
//   Streaming FM de-emphasis IIR filter (Q10 fixed point) placed between an
//   input FIFO and a first-word-fall-through output FIFO. The filter core
//   fires on any clock edge where the input FIFO holds a sample and the output
//   FIFO has room. When it fires it pops one input sample and pushes one output
//   sample on that same edge, so it can sustain one sample per clock.
//
// Ports
//   clock      in   1           single clock, rising edge
//   reset      in   1           asynchronous, active-high; clears all state
//   din        in   DATA_WIDTH  input sample, written when in_wr_en & !in_full
//   in_wr_en   in   1           input FIFO write strobe
//   in_full    out  1           input FIFO full
//   dout       out  DATA_WIDTH  output FIFO head, valid when !out_empty
//   out_rd_en  in   1           pop the output FIFO head at this edge
//   out_empty  out  1           output FIFO empty
// ----------------------------------------------------------------------------
module iir_fast_top #(
    parameter int                            DATA_WIDTH = 32,
    parameter int                            FIFO_DEPTH = 16,
    parameter int                            BITS       = 10,
    parameter logic signed [DATA_WIDTH-1:0]  X_COEF0    = 32'sh000000B2,
    parameter logic signed [DATA_WIDTH-1:0]  X_COEF1    = 32'sh000000B2,
    parameter logic signed [DATA_WIDTH-1:0]  Y_COEF0    = 32'sh00000000,
    parameter logic signed [DATA_WIDTH-1:0]  Y_COEF1    = 32'shFFFFFD66
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  in_wr_en,
    output logic                  in_full,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  out_rd_en,
    output logic                  out_empty
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              PW       = 2 * DATA_WIDTH;
    localparam logic [AW:0]     CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]     CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0]   PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]   PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic signed [PW-1:0] DEQ_BIAS = (64'sd1 <<< BITS) - 64'sd1;

    // Full-precision signed product of two samples.
    function automatic logic signed [PW-1:0] mul(input logic signed [DATA_WIDTH-1:0] a,
                                                 input logic signed [DATA_WIDTH-1:0] b);
        logic signed [PW-1:0] ae;
        logic signed [PW-1:0] be;
        ae = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
        be = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
        return ae * be;
    endfunction

    // Divide by 2**BITS rounding toward zero: negative products are biased up
    // before the arithmetic shift so that e.g. -178/1024 becomes 0, not -1.
    function automatic logic signed [DATA_WIDTH-1:0] deq(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] adj;
        if (p[PW-1]) begin
            adj = p + DEQ_BIAS;
        end else begin
            adj = p;
        end
        return DATA_WIDTH'(adj >>> BITS);
    endfunction

    // ------------------------------------------------------------------ input FIFO
    logic [DATA_WIDTH-1:0] in_mem_r [FIFO_DEPTH];
    logic [AW-1:0]         in_wr_ptr_r;
    logic [AW-1:0]         in_rd_ptr_r;
    logic [AW:0]           in_count_r;
    logic                  in_full_s;
    logic                  in_empty_s;
    logic                  in_push_s;

    // ----------------------------------------------------------------- output FIFO
    logic [DATA_WIDTH-1:0] out_mem_r [FIFO_DEPTH];
    logic [AW-1:0]         out_wr_ptr_r;
    logic [AW-1:0]         out_rd_ptr_r;
    logic [AW:0]           out_count_r;
    logic                  out_full_s;
    logic                  out_empty_s;
    logic                  out_pop_s;

    // ------------------------------------------------------------------ filter core
    // Only one sample of input history is needed: the feed-forward taps are
    // the incoming sample and x0.
    logic signed [DATA_WIDTH-1:0] x0_r;
    logic signed [DATA_WIDTH-1:0] y0_r;
    logic signed [DATA_WIDTH-1:0] y1_r;
    logic signed [DATA_WIDTH-1:0] x_in_s;
    logic signed [DATA_WIDTH-1:0] ax_s;
    logic signed [DATA_WIDTH-1:0] ay_s;
    logic                         fire_s;

    assign in_full_s   = (in_count_r == CNT_FULL);
    assign in_empty_s  = (in_count_r == CNT_ZERO);
    assign out_full_s  = (out_count_r == CNT_FULL);
    assign out_empty_s = (out_count_r == CNT_ZERO);

    assign in_push_s = in_wr_en & ~in_full_s;
    assign fire_s    = ~in_empty_s & ~out_full_s;
    assign out_pop_s = out_rd_en & ~out_empty_s;

    assign in_full   = in_full_s;
    assign out_empty = out_empty_s;

    // Head of the input FIFO and the filter arithmetic for the next fire.
    always_comb begin
        x_in_s = in_mem_r[in_rd_ptr_r];
        ax_s   = deq(mul(X_COEF0, x_in_s)) + deq(mul(X_COEF1, x0_r));
        ay_s   = deq(mul(Y_COEF0, y0_r))   + deq(mul(Y_COEF1, y1_r));
    end

    // Output head shown straight from storage; forced to zero while empty so
    // stale storage never leaks out after reset.
    always_comb begin
        if (out_empty_s) begin
            dout = {DATA_WIDTH{1'b0}};
        end else begin
            dout = out_mem_r[out_rd_ptr_r];
        end
    end

    // Input FIFO storage write.
    always_ff @(posedge clock) begin
        if (in_push_s) begin
            in_mem_r[in_wr_ptr_r] <= din;
        end
    end

    // Input FIFO pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_wr_ptr_r <= PTR_ZERO;
            in_rd_ptr_r <= PTR_ZERO;
            in_count_r  <= CNT_ZERO;
        end else begin
            if (in_push_s) begin
                in_wr_ptr_r <= in_wr_ptr_r + PTR_ONE;
            end
            if (fire_s) begin
                in_rd_ptr_r <= in_rd_ptr_r + PTR_ONE;
            end
            case ({in_push_s, fire_s})
                2'b10:   in_count_r <= in_count_r + CNT_ONE;
                2'b01:   in_count_r <= in_count_r - CNT_ONE;
                default: in_count_r <= in_count_r;
            endcase
        end
    end

    // Filter history; output is the previous y0, hence one sample of delay.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x0_r <= {DATA_WIDTH{1'b0}};
            y0_r <= {DATA_WIDTH{1'b0}};
            y1_r <= {DATA_WIDTH{1'b0}};
        end else if (fire_s) begin
            x0_r <= x_in_s;
            y1_r <= y0_r;
            y0_r <= ax_s + ay_s;
        end
    end

    // Output FIFO storage write; a fire only happens when there is room.
    always_ff @(posedge clock) begin
        if (fire_s) begin
            out_mem_r[out_wr_ptr_r] <= y0_r;
        end
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_wr_ptr_r <= PTR_ZERO;
            out_rd_ptr_r <= PTR_ZERO;
            out_count_r  <= CNT_ZERO;
        end else begin
            if (fire_s) begin
                out_wr_ptr_r <= out_wr_ptr_r + PTR_ONE;
            end
            if (out_pop_s) begin
                out_rd_ptr_r <= out_rd_ptr_r + PTR_ONE;
            end
            case ({fire_s, out_pop_s})
                2'b10:   out_count_r <= out_count_r + CNT_ONE;
                2'b01:   out_count_r <= out_count_r - CNT_ONE;
                default: out_count_r <= out_count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_fast_top.sv
// ----------------------------------------------------------------------------
// tb_iir_fast_top
//   Directed bench for iir_fast_top. Inputs are driven on the falling edge;
//   outputs are sampled on the falling edge before being popped on the next
//   rising edge. Expected outputs are held in a queue filled either with
//   hand-computed constants or by a small reference model of the filter.
// ----------------------------------------------------------------------------
module tb_iir_fast_top;

    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clock;
    logic          reset;
    logic [DW-1:0] din;
    logic          in_wr_en;
    logic          in_full;
    logic [DW-1:0] dout;
    logic          out_rd_en;
    logic          out_empty;

    int checks;
    int errors;
    int rd_count;
    int cyc;

    logic [DW-1:0] exp_q [$];

    logic signed [DW-1:0] x0_m;
    logic signed [DW-1:0] y0_m;
    logic signed [DW-1:0] y1_m;

    iir_fast_top dut (
        .clock     (clock),
        .reset     (reset),
        .din       (din),
        .in_wr_en  (in_wr_en),
        .in_full   (in_full),
        .dout      (dout),
        .out_rd_en (out_rd_en),
        .out_empty (out_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [DW-1:0] deq_m(input longint p);
        longint q;
        q = p / 64'sd1024;
        return q[DW-1:0];
    endfunction

    // Reference filter: queue the value that leaves the core for this sample.
    task automatic model_push(input logic signed [DW-1:0] x);
        logic signed [DW-1:0] ax;
        logic signed [DW-1:0] ay;
        ax = deq_m(longint'(32'sd178) * longint'(x)) + deq_m(longint'(32'sd178) * longint'(x0_m));
        ay = deq_m(longint'(32'sd0) * longint'(y0_m)) + deq_m(longint'(-32'sd666) * longint'(y1_m));
        exp_q.push_back(y0_m);
        y1_m = y0_m;
        y0_m = ax + ay;
        x0_m = x;
    endtask

    // One clock: drive inputs at the falling edge, check/pop the output head.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd, input logic acc);
        @(negedge clock);
        cyc++;
        in_wr_en  = wr;
        din       = d;
        out_rd_en = rd;
        if (acc) model_push(d);
        if (rd && !out_empty) begin
            if (exp_q.size() == 0) begin
                check("extra_out", {63'd0, out_empty}, 64'd1);
            end else begin
                check("dout", {32'd0, dout}, {32'd0, exp_q.pop_front()});
                rd_count++;
            end
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step(1'b0, 32'd0, 1'b1, 1'b0);
            n++;
        end
        check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        check({tag, "_empty"}, {63'd0, out_empty}, 64'd1);
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic reset_dut(input string tag);
        @(posedge clock);
        #3;
        reset     = 1'b1;
        in_wr_en  = 1'b0;
        out_rd_en = 1'b0;
        #1;
        check({tag, "_empty"}, {63'd0, out_empty}, 64'd1);
        check({tag, "_full"},  {63'd0, in_full},   64'd0);
        check({tag, "_dout"},  {32'd0, dout},      64'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        x0_m     = 32'sd0;
        y0_m     = 32'sd0;
        y1_m     = 32'sd0;
        rd_count = 0;
    endtask

    initial begin
        int cyc0;
        logic signed [DW-1:0] s;
        checks    = 0;
        errors    = 0;
        rd_count  = 0;
        cyc       = 0;
        reset     = 1'b1;
        din       = 32'd0;
        in_wr_en  = 1'b0;
        out_rd_en = 1'b0;
        x0_m      = 32'sd0;
        y0_m      = 32'sd0;
        y1_m      = 32'sd0;
        #1;
        check("por_empty", {63'd0, out_empty}, 64'd1);
        check("por_full",  {63'd0, in_full},   64'd0);
        check("por_dout",  {32'd0, dout},      64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Mid-stream reset discards buffered data.
        for (int i = 0; i < 3; i++) step(1'b1, 32'd5000, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        check("pre_rst_nonempty", {63'd0, out_empty}, 64'd0);
        reset_dut("rst_mid");

        // Step response with latency: written at edge t, visible after t+1.
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd178);
        exp_q.push_back(32'd356);
        step(1'b1, 32'd1024, 1'b0, 1'b0);
        step(1'b1, 32'd1024, 1'b0, 1'b0);
        check("lat_t", {63'd0, out_empty}, 64'd1);
        step(1'b1, 32'd1024, 1'b0, 1'b0);
        check("lat_t1", {63'd0, out_empty}, 64'd0);
        drain("step");
        check("step_y0", {32'd0, dut.y0_r}, 64'd241);
        reset_dut("rst_step");

        // Truncation toward zero: 178 * -1 / 1024 is 0, not -1.
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        step(1'b1, 32'd0, 1'b0, 1'b0);
        drain("trunc");
        reset_dut("rst_trunc");

        // Backpressure: 16 samples reach the full output FIFO, 16 more fill
        // the input FIFO, the last two writes are dropped.
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            step(1'b1, 32'(i * 3000 - 40000), 1'b0, (i < 2 * DEPTH) ? 1'b1 : 1'b0);
        end
        check("bp_in_full", {63'd0, in_full}, 64'd1);
        drain("bp");
        check("bp_count", 64'(rd_count), 64'(2 * DEPTH));
        check("bp_in_free", {63'd0, in_full}, 64'd0);

        // Read strobe held while empty, then more data continuing the history.
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
        check("edge_empty", {63'd0, out_empty}, 64'd1);
        for (int i = 0; i < 10; i++) step(1'b1, 32'(-i * 77777), 1'b1, 1'b1);
        drain("edge");
        reset_dut("rst_edge");

        // Streaming: one write per clock with reads whenever data is present.
        cyc0 = cyc;
        for (int i = 0; i < 100; i++) begin
            if (i % 17 == 0) s = -32'sd2000000000;
            else             s = 32'((i * 7919) % 4001 - 2000) * 32'sd37;
            step(1'b1, s, 1'b1, 1'b1);
        end
        drain("stream");
        check("stream_cycles", {63'd0, (cyc - cyc0) <= 105}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
